// File: rtl/mem_bus_arbiter_if.sv
// Cache-side and bus-side signal bundle of the memory bus arbiter.
// The slave modport is the arbiter's view; master is the surrounding caches and bus pins.
interface mem_bus_arbiter_if #(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13,
   parameter int ADDR_WIDTH     = 64,
   parameter int BEAT_WIDTH     = 3
);
   logic                      ic_mreq;
   logic [ADDR_WIDTH-1:0]     ic_maddr;
   logic                      ic_mgnt;
   logic                      ic_mvalid;
   logic [BUS_DATA_WIDTH-1:0] ic_mdata;
   logic                      ic_mdone;

   logic                      dc_mreq;
   logic                      dc_mwe;
   logic [ADDR_WIDTH-1:0]     dc_maddr;
   logic [BEAT_WIDTH-1:0]     dc_wbeat;
   logic [BUS_DATA_WIDTH-1:0] dc_mwdata;
   logic                      dc_mgnt;
   logic                      dc_mvalid;
   logic [BUS_DATA_WIDTH-1:0] dc_mdata;
   logic                      dc_mdone;

   logic                      bus_reqcyc;
   logic [BUS_DATA_WIDTH-1:0] bus_req;
   logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
   logic                      bus_reqack;
   logic                      bus_respcyc;
   logic [BUS_DATA_WIDTH-1:0] bus_resp;
   logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
   logic                      bus_respack;

   modport slave (
      input  ic_mreq, ic_maddr, dc_mreq, dc_mwe, dc_maddr, dc_mwdata,
             bus_reqack, bus_respcyc, bus_resp, bus_resptag,
      output ic_mgnt, ic_mvalid, ic_mdata, ic_mdone,
             dc_wbeat, dc_mgnt, dc_mvalid, dc_mdata, dc_mdone,
             bus_reqcyc, bus_req, bus_reqtag, bus_respack
   );

   modport master (
      output ic_mreq, ic_maddr, dc_mreq, dc_mwe, dc_maddr, dc_mwdata,
             bus_reqack, bus_respcyc, bus_resp, bus_resptag,
      input  ic_mgnt, ic_mvalid, ic_mdata, ic_mdone,
             dc_wbeat, dc_mgnt, dc_mvalid, dc_mdata, dc_mdone,
             bus_reqcyc, bus_req, bus_reqtag, bus_respack
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin owner of the external memory bus for I-cache fills and D-cache fills/writebacks.
// One 64B line transaction at a time; response beats are routed to the owner by tag.
module mem_bus_arbiter #(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13,
   parameter int BEATS          = 8
) (
   input  logic             clk,
   input  logic             reset,
   mem_bus_arbiter_if.slave io_bus
);
   localparam int ADDR_W   = 64;
   localparam int BEAT_W   = $clog2(BEATS);
   localparam int LINE_OFF = $clog2(BEATS * BUS_DATA_WIDTH / 8);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
   localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << LINE_OFF) - ADDR_W'(1));

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WDATA, S_RESP} state_t;

   state_t              r_state;
   logic                r_owner;       // 0 = I-cache, 1 = D-cache
   logic                r_dir;         // 1 = writeback
   logic                r_last_grant;
   logic                r_ic_mgnt;
   logic                r_dc_mgnt;
   logic [ADDR_W-1:0]   r_addr;
   logic [BEAT_W-1:0]   r_beat;

   logic                     w_grant_ic;
   logic                     w_grant_dc;
   logic                     w_last;
   logic                     w_accept;
   logic [BUS_TAG_WIDTH-1:0] w_tag;

   // On a tie the requester that did not win last time goes first.
   assign w_grant_ic = io_bus.ic_mreq && (!io_bus.dc_mreq || r_last_grant);
   assign w_grant_dc = io_bus.dc_mreq && (!io_bus.ic_mreq || !r_last_grant);
   assign w_tag      = {r_dir, {(BUS_TAG_WIDTH-2){1'b0}}, r_owner};
   assign w_last     = (r_beat == LAST_BEAT);
   assign w_accept   = (r_state == S_RESP) && io_bus.bus_respcyc &&
                       (io_bus.bus_resptag == w_tag);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_owner      <= 1'b0;
         r_dir        <= 1'b0;
         r_last_grant <= 1'b1;
         r_ic_mgnt    <= 1'b0;
         r_dc_mgnt    <= 1'b0;
         r_addr       <= '0;
         r_beat       <= '0;
      end else begin
         r_ic_mgnt <= 1'b0;
         r_dc_mgnt <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_grant_ic) begin
                  r_owner      <= 1'b0;
                  r_dir        <= 1'b0;
                  r_addr       <= io_bus.ic_maddr & LINE_MASK;
                  r_ic_mgnt    <= 1'b1;
                  r_last_grant <= 1'b0;
                  r_state      <= S_ADDR;
               end else if (w_grant_dc) begin
                  r_owner      <= 1'b1;
                  r_dir        <= io_bus.dc_mwe;
                  r_addr       <= io_bus.dc_maddr & LINE_MASK;
                  r_dc_mgnt    <= 1'b1;
                  r_last_grant <= 1'b1;
                  r_state      <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (io_bus.bus_reqack) begin
                  r_beat  <= '0;
                  r_state <= r_dir ? S_WDATA : S_RESP;
               end
            end
            S_WDATA: begin
               if (w_last) begin
                  r_beat  <= '0;
                  r_state <= S_IDLE;
               end else begin
                  r_beat <= r_beat + BEAT_W'(1);
               end
            end
            S_RESP: begin
               if (w_accept) begin
                  if (w_last) begin
                     r_beat  <= '0;
                     r_state <= S_IDLE;
                  end else begin
                     r_beat <= r_beat + BEAT_W'(1);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      io_bus.ic_mgnt     = r_ic_mgnt;
      io_bus.dc_mgnt     = r_dc_mgnt;
      io_bus.bus_reqcyc  = 1'b0;
      io_bus.bus_req     = '0;
      io_bus.bus_reqtag  = '0;
      io_bus.dc_wbeat    = '0;
      io_bus.bus_respack = w_accept;
      io_bus.ic_mvalid   = w_accept && !r_owner;
      io_bus.dc_mvalid   = w_accept && r_owner;
      io_bus.ic_mdata    = (w_accept && !r_owner) ? io_bus.bus_resp : '0;
      io_bus.dc_mdata    = (w_accept && r_owner)  ? io_bus.bus_resp : '0;
      io_bus.ic_mdone    = w_accept && !r_owner && w_last;
      io_bus.dc_mdone    = w_accept && r_owner && w_last;

      case (r_state)
         S_ADDR: begin
            io_bus.bus_reqcyc = 1'b1;
            io_bus.bus_req    = r_addr;
            io_bus.bus_reqtag = w_tag;
         end
         S_WDATA: begin
            io_bus.bus_reqcyc = 1'b1;
            io_bus.bus_req    = io_bus.dc_mwdata;
            io_bus.bus_reqtag = w_tag;
            io_bus.dc_wbeat   = r_beat;
            io_bus.dc_mdone   = w_last;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: stimulus pushes expected events, a negedge monitor pops and compares.
module tb_mem_bus_arbiter;
   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mem_bus_arbiter_if mb ();

   mem_bus_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .io_bus(mb)
   );

   typedef enum logic [1:0] {EV_GNT, EV_RBEAT, EV_WBEAT, EV_DONE} ev_kind_t;
   typedef struct packed {
      ev_kind_t    kind;
      logic [1:0]  who;    // {dc, ic} mgnt or mvalid
      logic [1:0]  done;   // {dc, ic} mdone
      logic [12:0] aux;    // tag for grants, beat index for write beats
      logic [63:0] data;
   } ev_t;

   ev_t exp_q[$];
   int  n_checks = 0;
   int  n_errors = 0;
   logic in_wr = 1'b0;

   function automatic logic [63:0] wdata_of(input logic [2:0] b);
      return 64'hD0D0_0000_0000_0000 + 64'(b) * 64'h1111;
   endfunction

   always_comb mb.dc_mwdata = wdata_of(mb.dc_wbeat);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic ev_t mk_ev(input ev_kind_t k, input logic [1:0] who, input logic [1:0] done,
                                 input logic [12:0] aux, input logic [63:0] data);
      ev_t e;
      e.kind = k; e.who = who; e.done = done; e.aux = aux; e.data = data;
      return e;
   endfunction

   function automatic logic [63:0] hdr(input ev_t e);
      return 64'({e.kind, e.who, e.done, e.aux});
   endfunction

   always @(negedge clk) begin
      ev_t  obs;
      ev_t  expv;
      logic have;
      have = 1'b1;
      obs  = '0;
      if (mb.ic_mgnt || mb.dc_mgnt)
         obs = mk_ev(EV_GNT, {mb.dc_mgnt, mb.ic_mgnt}, {mb.dc_mdone, mb.ic_mdone},
                     mb.bus_reqtag, mb.bus_req);
      else if (mb.ic_mvalid || mb.dc_mvalid)
         obs = mk_ev(EV_RBEAT, {mb.dc_mvalid, mb.ic_mvalid}, {mb.dc_mdone, mb.ic_mdone},
                     13'h0, mb.dc_mvalid ? mb.dc_mdata : mb.ic_mdata);
      else if (in_wr && mb.bus_reqcyc)
         obs = mk_ev(EV_WBEAT, {mb.dc_mvalid, mb.ic_mvalid}, {mb.dc_mdone, mb.ic_mdone},
                     {10'b0, mb.dc_wbeat}, mb.bus_req);
      else if (mb.ic_mdone || mb.dc_mdone)
         obs = mk_ev(EV_DONE, 2'b00, {mb.dc_mdone, mb.ic_mdone}, 13'h0, 64'h0);
      else
         have = 1'b0;

      if (have) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_event: actual kind=%0d hdr=%h data=%h required=no event",
                     obs.kind, hdr(obs), obs.data);
         end else begin
            expv = exp_q.pop_front();
            check("event_hdr", hdr(obs), hdr(expv));
            check("event_data", obs.data, expv.data);
         end
      end

      if (reset || mb.dc_mdone) in_wr = 1'b0;
      else if (mb.bus_reqcyc && mb.bus_reqack && mb.bus_reqtag[12]) in_wr = 1'b1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_gnt(input bit is_dc, input bit wr, input logic [63:0] line_addr);
      exp_q.push_back(mk_ev(EV_GNT, is_dc ? 2'b10 : 2'b01, 2'b00,
                            {wr, 11'b0, is_dc}, line_addr));
   endtask

   task automatic push_read_beats(input bit is_dc, input logic [63:0] seed, input int n);
      for (int i = 0; i < n; i++)
         exp_q.push_back(mk_ev(EV_RBEAT, is_dc ? 2'b10 : 2'b01,
                               (i == 7) ? (is_dc ? 2'b10 : 2'b01) : 2'b00,
                               13'h0, seed + 64'(i)));
   endtask

   task automatic ack_addr();
      mb.bus_reqack = 1'b1;
      tick();
      mb.bus_reqack = 1'b0;
   endtask

   task automatic send_beats(input logic [12:0] tag, input logic [63:0] seed,
                             input int first, input int n);
      for (int i = first; i < first + n; i++) begin
         mb.bus_respcyc = 1'b1;
         mb.bus_resptag = tag;
         mb.bus_resp    = seed + 64'(i);
         tick();
      end
      mb.bus_respcyc = 1'b0;
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_ctl"},
            64'({mb.ic_mgnt, mb.ic_mvalid, mb.ic_mdone, mb.dc_mgnt, mb.dc_mvalid, mb.dc_mdone,
                 mb.bus_reqcyc, mb.bus_respack, mb.dc_wbeat, mb.bus_reqtag}), 64'h0);
      check({name, "_data"}, mb.ic_mdata | mb.dc_mdata | mb.bus_req, 64'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      mb.ic_mreq = 1'b0; mb.ic_maddr = '0;
      mb.dc_mreq = 1'b0; mb.dc_mwe = 1'b0; mb.dc_maddr = '0;
      mb.bus_reqack = 1'b0; mb.bus_respcyc = 1'b0; mb.bus_resp = '0; mb.bus_resptag = '0;
      repeat (2) tick();

      // Reset state, with a matching-looking beat on the bus that must not be acked
      mb.bus_respcyc = 1'b1;
      #1;
      check_all_zero("reset_state");
      mb.bus_respcyc = 1'b0;
      reset = 1'b0;
      tick();

      // 1: single I-cache read
      mb.ic_mreq = 1'b1; mb.ic_maddr = 64'h1047;
      push_gnt(1'b0, 1'b0, 64'h1040);
      push_read_beats(1'b0, 64'h1111_0000_0000_0000, 8);
      tick();
      check("t1_gnt_next_cycle", {62'b0, mb.ic_mgnt, mb.bus_reqcyc}, 64'h3);
      ack_addr();
      send_beats(13'h0000, 64'h1111_0000_0000_0000, 0, 8);
      mb.ic_mreq = 1'b0;
      tick();

      // 2: simultaneous requests right after reset, I-cache wins the tie
      reset = 1'b1;
      tick();
      reset = 1'b0;
      mb.ic_mreq = 1'b1; mb.ic_maddr = 64'h4080;
      mb.dc_mreq = 1'b1; mb.dc_mwe = 1'b0; mb.dc_maddr = 64'h5123;
      push_gnt(1'b0, 1'b0, 64'h4080);
      push_read_beats(1'b0, 64'h2222_0000_0000_0000, 8);
      push_gnt(1'b1, 1'b0, 64'h5100);
      push_read_beats(1'b1, 64'h3333_0000_0000_0000, 8);
      tick();
      check("t2_tie_ic_first", {62'b0, mb.ic_mgnt, mb.dc_mgnt}, 64'h2);
      ack_addr();
      send_beats(13'h0000, 64'h2222_0000_0000_0000, 0, 8);
      mb.ic_mreq = 1'b0;
      check("t2_grant_cycle_after_mdone", {62'b0, mb.dc_mgnt, mb.bus_reqcyc}, 64'h0);
      tick();
      check("t2_dc_gnt", 64'({mb.dc_mgnt, mb.bus_reqcyc, mb.bus_reqtag}), 64'({2'b11, 13'h0001}));
      ack_addr();
      send_beats(13'h0001, 64'h3333_0000_0000_0000, 0, 8);
      mb.dc_mreq = 1'b0;
      tick();

      // 3: D-cache writeback
      mb.dc_mreq = 1'b1; mb.dc_mwe = 1'b1; mb.dc_maddr = 64'h2000;
      push_gnt(1'b1, 1'b1, 64'h2000);
      for (int i = 0; i < 8; i++)
         exp_q.push_back(mk_ev(EV_WBEAT, 2'b00, (i == 7) ? 2'b10 : 2'b00,
                               13'(i), wdata_of(3'(i))));
      tick();
      check("t3_wr_tag", 64'(mb.bus_reqtag), 64'h1001);
      ack_addr();
      repeat (8) tick();
      check("t3_bus_released", {63'b0, mb.bus_reqcyc}, 64'h0);
      mb.dc_mreq = 1'b0; mb.dc_mwe = 1'b0;
      tick();

      // 4: foreign-tag beat and a gap during an I-cache read
      mb.ic_mreq = 1'b1; mb.ic_maddr = 64'h6010;
      push_gnt(1'b0, 1'b0, 64'h6000);
      push_read_beats(1'b0, 64'h4444_0000_0000_0000, 8);
      tick();
      ack_addr();
      send_beats(13'h0000, 64'h4444_0000_0000_0000, 0, 3);
      mb.bus_respcyc = 1'b1; mb.bus_resptag = 13'h0001; mb.bus_resp = 64'hDEAD_BEEF;
      #1;
      check("t4_foreign_tag_ignored", {61'b0, mb.bus_respack, mb.ic_mvalid, mb.dc_mvalid}, 64'h0);
      tick();
      mb.bus_respcyc = 1'b0;
      tick();
      mb.bus_respcyc = 1'b1; mb.bus_resptag = 13'h0000; mb.bus_resp = 64'h4444_0000_0000_0003;
      #1;
      check("t4_own_tag_acked", {62'b0, mb.bus_respack, mb.ic_mvalid}, 64'h3);
      tick();
      send_beats(13'h0000, 64'h4444_0000_0000_0000, 4, 4);
      mb.ic_mreq = 1'b0;
      tick();

      // 5: address beat held while the bus withholds reqack
      mb.dc_mreq = 1'b1; mb.dc_mwe = 1'b0; mb.dc_maddr = 64'h7040;
      push_gnt(1'b1, 1'b0, 64'h7040);
      push_read_beats(1'b1, 64'h5555_0000_0000_0000, 8);
      tick();
      for (int k = 0; k < 5; k++) begin
         mb.bus_respcyc = (k == 2);
         mb.bus_resptag = 13'h0001;
         #1;
         check("t5_hold_req", mb.bus_req, 64'h7040);
         check("t5_hold_cyc_tag", 64'({mb.bus_reqcyc, mb.bus_respack, mb.bus_reqtag}),
               64'({2'b10, 13'h0001}));
         tick();
      end
      mb.bus_respcyc = 1'b0;
      ack_addr();
      send_beats(13'h0001, 64'h5555_0000_0000_0000, 0, 8);
      mb.dc_mreq = 1'b0;
      tick();

      // 6: reset after three beats abandons the read; a fresh request still completes
      mb.ic_mreq = 1'b1; mb.ic_maddr = 64'h8000;
      push_gnt(1'b0, 1'b0, 64'h8000);
      push_read_beats(1'b0, 64'h6666_0000_0000_0000, 3);
      tick();
      ack_addr();
      send_beats(13'h0000, 64'h6666_0000_0000_0000, 0, 3);
      reset = 1'b1; mb.ic_mreq = 1'b0;
      tick();
      check_all_zero("t6_after_reset");
      reset = 1'b0;
      mb.bus_respcyc = 1'b1; mb.bus_resptag = 13'h0000; mb.bus_resp = 64'h6666_0000_0000_0003;
      #1;
      check("t6_stale_not_acked", {62'b0, mb.bus_respack, mb.ic_mvalid}, 64'h0);
      tick();
      mb.bus_respcyc = 1'b0;
      mb.dc_mreq = 1'b1; mb.dc_mwe = 1'b0; mb.dc_maddr = 64'h3000;
      push_gnt(1'b1, 1'b0, 64'h3000);
      push_read_beats(1'b1, 64'h7777_0000_0000_0000, 8);
      tick();
      check("t6_fresh_gnt", {63'b0, mb.dc_mgnt}, 64'h1);
      ack_addr();
      send_beats(13'h0001, 64'h7777_0000_0000_0000, 0, 8);
      mb.dc_mreq = 1'b0;
      repeat (3) tick();

      check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
